// File: rtl/data_path_pkg.sv
// Shared types for the fetch->decode boundary: the queued fetch entry and the default bubble.
package data_path_pkg;

  localparam int          XLEN_DEFAULT      = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc_plus4;
    logic [XLEN_DEFAULT-1:0] pred_target;
    logic                    pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupled fetch->decode queue: DEPTH-entry circular FIFO of fetch entries.
// The head is presented combinationally; an empty queue shows a NOP bubble to decode.
module fetch_queue
  import data_path_pkg::*;
#(
  parameter int               DEPTH       = 4,
  parameter int               XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  NOP_INSTR   = NOP_INSTR_DEFAULT,
  parameter bit               BYPASS_FULL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ValidF,
  input  logic [XLEN-1:0]          InstrF,
  input  logic [XLEN-1:0]          PCF,
  input  logic [XLEN-1:0]          PCPlus4F,
  input  logic [XLEN-1:0]          PredPCTargetF,
  input  logic                     PCSrcPredF,
  output logic                     ReadyF,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic                     ValidD,
  output logic [XLEN-1:0]          InstrD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  output logic [XLEN-1:0]          PredPCTargetD,
  output logic                     PCSrcPredD,
  output logic [$clog2(DEPTH):0]   CountQ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t              mem_r [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   enq_s;
  logic                   deq_s;
  fq_entry_t              head_s;
  fq_entry_t              wr_entry_s;

  // Handshake, head decode and bubble insertion.
  always_comb begin
    wr_entry_s = '{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F,
                   pred_target: PredPCTargetF, pred_taken: PCSrcPredF};
    head_s     = mem_r[rd_ptr_r];
    ValidD     = (count_r != {CNT_W{1'b0}});
    deq_s      = ValidD & ~StallD;
    ReadyF     = (count_r < CNT_W'(DEPTH)) | (BYPASS_FULL & deq_s);
    enq_s      = ValidF & ReadyF;
    CountQ     = count_r;
    if (ValidD) begin
      InstrD        = head_s.instr;
      PCD           = head_s.pc;
      PCPlus4D      = head_s.pc_plus4;
      PredPCTargetD = head_s.pred_target;
      PCSrcPredD    = head_s.pred_taken;
    end else begin
      InstrD        = NOP_INSTR;
      PCD           = {XLEN{1'b0}};
      PCPlus4D      = {XLEN{1'b0}};
      PredPCTargetD = {XLEN{1'b0}};
      PCSrcPredD    = 1'b0;
    end
  end

  // Storage, pointers and occupancy; a flush drops any same-cycle enq/deq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (FlushD) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        mem_r[wr_ptr_r] <= wr_entry_s;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4, bypass enabled).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidF;
  logic [31:0] InstrF, PCF, PCPlus4F, PredPCTargetF;
  logic        PCSrcPredF;
  logic        ReadyF;
  logic        StallD, FlushD;
  logic        ValidD;
  logic [31:0] InstrD, PCD, PCPlus4D, PredPCTargetD;
  logic        PCSrcPredD;
  logic [2:0]  CountQ;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(4), .XLEN(32), .NOP_INSTR(32'h0000_0013), .BYPASS_FULL(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .PredPCTargetF(PredPCTargetF), .PCSrcPredF(PCSrcPredF), .ReadyF(ReadyF),
    .StallD(StallD), .FlushD(FlushD),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PredPCTargetD(PredPCTargetD), .PCSrcPredD(PCSrcPredD), .CountQ(CountQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vf;
    logic [31:0] pc;
    logic        st;
    logic        fl;
    logic        exp_ready;
    logic        exp_vd;
    logic [31:0] exp_pcd;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1000_0000 | pc;
  endfunction

  task automatic add(input logic vf, input logic [31:0] pc, input logic st, input logic fl,
                     input logic rdy, input logic vd, input logic [31:0] pcd, input logic [2:0] cnt);
    vec_t v;
    v = '{vf: vf, pc: pc, st: st, fl: fl, exp_ready: rdy, exp_vd: vd, exp_pcd: pcd, exp_cnt: cnt};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vf, input logic [31:0] pc, input logic st, input logic fl);
    ValidF        = vf;
    PCF           = pc;
    InstrF        = instr_of(pc);
    PCPlus4F      = pc + 32'd4;
    PredPCTargetF = pc + 32'h100;
    PCSrcPredF    = pc[2];
    StallD        = st;
    FlushD        = fl;
  endtask

  // Compare all head outputs against what an entry with PC 'pcd' (or a bubble) must show.
  task automatic check_head(input string tag, input logic vd, input logic [31:0] pcd, input logic [2:0] cnt);
    check({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, vd});
    check({tag, ".CountQ"}, {29'd0, CountQ}, {29'd0, cnt});
    if (vd) begin
      check({tag, ".PCD"},    PCD,    pcd);
      check({tag, ".InstrD"}, InstrD, instr_of(pcd));
      check({tag, ".PCPlus4D"}, PCPlus4D, pcd + 32'd4);
      check({tag, ".PredPCTargetD"}, PredPCTargetD, pcd + 32'h100);
      check({tag, ".PCSrcPredD"}, {31'd0, PCSrcPredD}, {31'd0, pcd[2]});
    end else begin
      check({tag, ".InstrD"}, InstrD, 32'h0000_0013);
      check({tag, ".PCD"},    PCD,    32'd0);
      check({tag, ".PCSrcPredD"}, {31'd0, PCSrcPredD}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_head("reset", 1'b0, 32'd0, 3'd0);
    check("reset.ReadyF", {31'd0, ReadyF}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Streaming through, then fill under stall, then full with bypass.
    add(1, 32'h00, 0, 0, 1, 1, 32'h00, 3'd1);
    add(1, 32'h04, 0, 0, 1, 1, 32'h04, 3'd1);
    add(1, 32'h08, 0, 0, 1, 1, 32'h08, 3'd1);
    add(0, 32'h00, 0, 0, 1, 0, 32'h00, 3'd0);
    add(1, 32'h00, 1, 0, 1, 1, 32'h00, 3'd1);
    add(1, 32'h04, 1, 0, 1, 1, 32'h00, 3'd2);
    add(1, 32'h08, 1, 0, 1, 1, 32'h00, 3'd3);
    add(1, 32'h0C, 1, 0, 1, 1, 32'h00, 3'd4);
    add(1, 32'h10, 1, 0, 0, 1, 32'h00, 3'd4);
    add(1, 32'h10, 0, 0, 1, 1, 32'h04, 3'd4);
    add(1, 32'h14, 0, 0, 1, 1, 32'h08, 3'd4);
    add(1, 32'h18, 0, 0, 1, 1, 32'h0C, 3'd4);
    add(1, 32'h1C, 0, 0, 1, 1, 32'h10, 3'd4);
    add(1, 32'h20, 0, 0, 1, 1, 32'h14, 3'd4);
    add(1, 32'h24, 0, 0, 1, 1, 32'h18, 3'd4);
    add(0, 32'h00, 0, 0, 1, 1, 32'h1C, 3'd3);
    add(0, 32'h00, 0, 0, 1, 1, 32'h20, 3'd2);
    add(0, 32'h00, 0, 0, 1, 1, 32'h24, 3'd1);
    add(0, 32'h00, 0, 0, 1, 0, 32'h00, 3'd0);
    // Flush at occupancy 3 with a same-cycle enqueue, stall also raised.
    add(1, 32'h30, 1, 0, 1, 1, 32'h30, 3'd1);
    add(1, 32'h34, 1, 0, 1, 1, 32'h30, 3'd2);
    add(1, 32'h38, 1, 0, 1, 1, 32'h30, 3'd3);
    add(1, 32'h40, 1, 1, 1, 0, 32'h00, 3'd0);
    add(0, 32'h00, 0, 0, 1, 0, 32'h00, 3'd0);
    // Empty with stall: entry accepted and held.
    add(1, 32'h50, 1, 0, 1, 1, 32'h50, 3'd1);
    add(0, 32'h00, 1, 0, 1, 1, 32'h50, 3'd1);
    add(0, 32'h00, 0, 0, 1, 0, 32'h00, 3'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].vf, vecs[i].pc, vecs[i].st, vecs[i].fl);
      #1;
      check($sformatf("v%0d.ReadyF", i), {31'd0, ReadyF}, {31'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      check_head($sformatf("v%0d", i), vecs[i].exp_vd, vecs[i].exp_pcd, vecs[i].exp_cnt);
    end

    // Asynchronous reset mid-stream at occupancy 2.
    @(negedge clk);
    drive(1'b1, 32'h60, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h64, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_head("pre_rst", 1'b1, 32'h60, 3'd2);
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_head("async_rst", 1'b0, 32'd0, 3'd0);
    check("async_rst.ReadyF", {31'd0, ReadyF}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h70, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_head("post_rst", 1'b1, 32'h70, 3'd1);
    check("post_rst.rd_ptr", {30'd0, dut.rd_ptr_r}, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_head("post_rst_drain", 1'b0, 32'd0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
